// File: rtl/turn_signal_ctrl.sv
// Arbitrates stalk, lane-change tap and hazard requests into left/right commands
// and a paced step enable for the tail-light sequencer, plus a separate hazard lamp.
module turn_signal_ctrl #(
    parameter int TICK_DIV     = 25_000_000,
    parameter int LANE_FLASHES = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   req_left,
    input  logic                                   req_right,
    input  logic                                   hazard,
    input  logic                                   lane_pulse_left,
    input  logic                                   lane_pulse_right,
    output logic                                   seq_left,
    output logic                                   seq_right,
    output logic                                   step,
    output logic                                   hazard_lamp,
    output logic [1:0]                             owner,
    output logic                                   busy,
    output logic [2:0]                             dbg_state,
    output logic [$clog2(4*LANE_FLASHES+1)-1:0]    dbg_lane_cnt
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int LC_W  = $clog2(4*LANE_FLASHES+1);
    localparam logic [CNT_W-1:0] DIV_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [LC_W-1:0]  LANE_LOAD = LC_W'(4*LANE_FLASHES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD_L = 3'd1,
        S_HOLD_R = 3'd2,
        S_LANE_L = 3'd3,
        S_LANE_R = 3'd4,
        S_GAP    = 3'd5,
        S_HAZ    = 3'd6
    } state_t;

    state_t            state_q, state_d, target_q, target_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [LC_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [1:0]        phase_q, phase_d;
    logic              step_q;
    logic              seq_left_q, seq_right_q, hazard_lamp_q, busy_q;
    logic [1:0]        owner_q;

    // A held request or tap only counts when exactly one side is asserted.
    logic held_l, held_r, tap_l, tap_r;
    assign held_l = req_left & ~req_right;
    assign held_r = req_right & ~req_left;
    assign tap_l  = lane_pulse_left & ~lane_pulse_right;
    assign tap_r  = lane_pulse_right & ~lane_pulse_left;

    assign div_d = (div_q == DIV_MAX) ? '0 : div_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        lane_cnt_d = lane_cnt_q;
        phase_d    = phase_q;
        if (hazard) begin
            if (state_q != S_HAZ) begin
                state_d = S_HAZ;
                phase_d = 2'd0;
            end else if (step_q) begin
                phase_d = phase_q + 2'd1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (held_l)     state_d = S_HOLD_L;
                    else if (held_r) state_d = S_HOLD_R;
                    else if (tap_l) begin state_d = S_LANE_L; lane_cnt_d = LANE_LOAD; end
                    else if (tap_r) begin state_d = S_LANE_R; lane_cnt_d = LANE_LOAD; end
                end
                S_HOLD_L: begin
                    if (held_r)      begin state_d = S_GAP; target_d = S_HOLD_R; end
                    else if (!held_l) state_d = S_IDLE;
                end
                S_HOLD_R: begin
                    if (held_l)      begin state_d = S_GAP; target_d = S_HOLD_L; end
                    else if (!held_r) state_d = S_IDLE;
                end
                S_LANE_L: begin
                    if (held_l)     state_d = S_HOLD_L;
                    else if (held_r) begin state_d = S_GAP; target_d = S_HOLD_R; end
                    else if (tap_r)  begin state_d = S_GAP; target_d = S_LANE_R; end
                    else if (tap_l)  lane_cnt_d = LANE_LOAD;
                    else if (step_q) begin
                        if (lane_cnt_q <= LC_W'(1)) state_d = S_IDLE;
                        else lane_cnt_d = lane_cnt_q - LC_W'(1);
                    end
                end
                S_LANE_R: begin
                    if (held_r)     state_d = S_HOLD_R;
                    else if (held_l) begin state_d = S_GAP; target_d = S_HOLD_L; end
                    else if (tap_l)  begin state_d = S_GAP; target_d = S_LANE_L; end
                    else if (tap_r)  lane_cnt_d = LANE_LOAD;
                    else if (step_q) begin
                        if (lane_cnt_q <= LC_W'(1)) state_d = S_IDLE;
                        else lane_cnt_d = lane_cnt_q - LC_W'(1);
                    end
                end
                // Sequencer is held off until the next step clears its pattern.
                S_GAP: begin
                    if (step_q) begin
                        case (target_q)
                            S_HOLD_L: state_d = held_l ? S_HOLD_L : S_IDLE;
                            S_HOLD_R: state_d = held_r ? S_HOLD_R : S_IDLE;
                            S_LANE_L: begin state_d = S_LANE_L; lane_cnt_d = LANE_LOAD; end
                            S_LANE_R: begin state_d = S_LANE_R; lane_cnt_d = LANE_LOAD; end
                            default:  state_d = S_IDLE;
                        endcase
                    end
                end
                S_HAZ: begin
                    if (held_l)      state_d = S_HOLD_L;
                    else if (held_r) state_d = S_HOLD_R;
                    else             state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (state_d != S_LANE_L && state_d != S_LANE_R) lane_cnt_d = '0;
        if (state_d != S_HAZ) phase_d = 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            target_q      <= S_IDLE;
            div_q         <= '0;
            step_q        <= 1'b0;
            lane_cnt_q    <= '0;
            phase_q       <= 2'd0;
            seq_left_q    <= 1'b0;
            seq_right_q   <= 1'b0;
            hazard_lamp_q <= 1'b0;
            owner_q       <= 2'b00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            div_q         <= div_d;
            step_q        <= (div_q == DIV_MAX);
            lane_cnt_q    <= lane_cnt_d;
            phase_q       <= phase_d;
            seq_left_q    <= (state_d == S_HOLD_L) || (state_d == S_LANE_L);
            seq_right_q   <= (state_d == S_HOLD_R) || (state_d == S_LANE_R);
            hazard_lamp_q <= (state_d == S_HAZ) && !phase_d[1];
            busy_q        <= (state_d != S_IDLE);
            case (state_d)
                S_HOLD_L, S_LANE_L: owner_q <= 2'b01;
                S_HOLD_R, S_LANE_R: owner_q <= 2'b10;
                S_HAZ:              owner_q <= 2'b11;
                default:            owner_q <= 2'b00;
            endcase
        end
    end

    assign seq_left     = seq_left_q;
    assign seq_right    = seq_right_q;
    assign step         = step_q;
    assign hazard_lamp  = hazard_lamp_q;
    assign owner        = owner_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;
    assign dbg_lane_cnt = lane_cnt_q;
endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Bench for turn_signal_ctrl: directed scenarios then random traffic, each cycle
// compared against a mode/side reference model derived from the request rules.
module tb_turn_signal_ctrl;
  localparam int TICK_DIV     = 4;
  localparam int LANE_FLASHES = 3;
  localparam int LOAD         = 4 * LANE_FLASHES;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic req_left, req_right, hazard, lane_pulse_left, lane_pulse_right;
  logic seq_left, seq_right, step, hazard_lamp, busy;
  logic [1:0] owner;
  logic [2:0] dbg_state;
  logic [3:0] dbg_lane_cnt;

  turn_signal_ctrl #(.TICK_DIV(TICK_DIV), .LANE_FLASHES(LANE_FLASHES)) dut (
    .clk(clk), .reset(reset),
    .req_left(req_left), .req_right(req_right), .hazard(hazard),
    .lane_pulse_left(lane_pulse_left), .lane_pulse_right(lane_pulse_right),
    .seq_left(seq_left), .seq_right(seq_right), .step(step),
    .hazard_lamp(hazard_lamp), .owner(owner), .busy(busy),
    .dbg_state(dbg_state), .dbg_lane_cnt(dbg_lane_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  // reference model: mode + side, with pacing from cycle arithmetic
  localparam int M_IDLE = 0, M_HOLD = 1, M_LANE = 2, M_GAP = 3, M_HAZ = 4;
  int m_mode, m_side, m_left, m_haz_steps, m_cyc, m_tgt_hold, m_tgt_side;
  bit m_step;

  task automatic model_reset();
    m_mode = M_IDLE; m_side = 0; m_left = 0; m_haz_steps = 0;
    m_cyc = 0; m_step = 1'b0; m_tgt_hold = 0; m_tgt_side = 0;
  endtask

  task automatic model_edge(input bit rl, input bit rr, input bit hz, input bit tl, input bit tr);
    bit st;
    int held, tap;
    st   = m_step;
    held = (rl ^ rr) ? (rl ? 0 : 1) : -1;
    tap  = (tl ^ tr) ? (tl ? 0 : 1) : -1;
    m_cyc++;
    if (hz) begin
      if (m_mode != M_HAZ) begin m_mode = M_HAZ; m_haz_steps = 0; end
      else if (st) m_haz_steps++;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (held >= 0) begin m_mode = M_HOLD; m_side = held; end
          else if (tap >= 0) begin m_mode = M_LANE; m_side = tap; m_left = LOAD; end
        end
        M_HOLD: begin
          if (held == m_side) ;
          else if (held >= 0) begin m_mode = M_GAP; m_tgt_hold = 1; m_tgt_side = held; end
          else m_mode = M_IDLE;
        end
        M_LANE: begin
          if (held == m_side) m_mode = M_HOLD;
          else if (held >= 0) begin m_mode = M_GAP; m_tgt_hold = 1; m_tgt_side = held; end
          else if (tap >= 0 && tap != m_side) begin m_mode = M_GAP; m_tgt_hold = 0; m_tgt_side = tap; end
          else if (tap == m_side) m_left = LOAD;
          else if (st) begin
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
          end
        end
        M_GAP: begin
          if (st) begin
            if (m_tgt_hold == 1) begin
              if (held == m_tgt_side) begin m_mode = M_HOLD; m_side = m_tgt_side; end
              else m_mode = M_IDLE;
            end else begin
              m_mode = M_LANE; m_side = m_tgt_side; m_left = LOAD;
            end
          end
        end
        default: begin
          if (held >= 0) begin m_mode = M_HOLD; m_side = held; end
          else m_mode = M_IDLE;
        end
      endcase
    end
    if (m_mode != M_LANE) m_left = 0;
    m_step = (m_cyc % TICK_DIV) == 0;
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    bit lane_or_hold;
    logic [1:0] e_owner;
    lane_or_hold = (m_mode == M_HOLD) || (m_mode == M_LANE);
    if (m_mode == M_HAZ) e_owner = 2'b11;
    else if (lane_or_hold) e_owner = (m_side == 0) ? 2'b01 : 2'b10;
    else e_owner = 2'b00;
    check({where, ":seq_left"},  8'(seq_left),  8'(lane_or_hold && m_side == 0));
    check({where, ":seq_right"}, 8'(seq_right), 8'(lane_or_hold && m_side == 1));
    check({where, ":step"},      8'(step),      8'(m_step));
    check({where, ":hazard_lamp"}, 8'(hazard_lamp),
          8'(m_mode == M_HAZ && ((m_haz_steps / 2) % 2) == 0));
    check({where, ":owner"},     8'(owner),     8'(e_owner));
    check({where, ":busy"},      8'(busy),      8'(m_mode != M_IDLE));
    check({where, ":lane_cnt"},  8'(dbg_lane_cnt), 8'(m_left));
  endtask

  // driver: entered just after a falling edge, leaves at the next falling edge
  task automatic cyc(input string where, input bit rl, input bit rr, input bit hz,
                     input bit tl, input bit tr);
    req_left = rl; req_right = rr; hazard = hz;
    lane_pulse_left = tl; lane_pulse_right = tr;
    @(posedge clk);
    model_edge(rl, rr, hz, tl, tr);
    #1;
    check_all(where);
    @(negedge clk);
    lane_pulse_left = 1'b0; lane_pulse_right = 1'b0;
  endtask

  initial begin
    bit rl, rr, hz, tl, tr;
    int sel;
    reset = 1'b1;
    req_left = 1'b0; req_right = 1'b0; hazard = 1'b0;
    lane_pulse_left = 1'b0; lane_pulse_right = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    model_reset();

    // idle pacing: step on cycles 4, 8, 12
    repeat (13) cyc("idle", 0, 0, 0, 0, 0);
    // lane-change tap left, run through all 12 steps
    cyc("tap_l", 0, 0, 0, 1, 0);
    repeat (56) cyc("lane_l", 0, 0, 0, 0, 0);
    // held left, then swap to held right through the gap
    repeat (9) cyc("hold_l", 1, 0, 0, 0, 0);
    repeat (10) cyc("swap_r", 0, 1, 0, 0, 0);
    // hazard over a held left, then drop hazard with left still held
    repeat (6) cyc("hold_l2", 1, 0, 0, 0, 0);
    repeat (22) cyc("haz", 1, 0, 1, 0, 0);
    repeat (5) cyc("haz_off", 1, 0, 0, 0, 0);
    // tap left while holding right is ignored
    repeat (6) cyc("hold_r", 0, 1, 0, 0, 0);
    cyc("tap_in_hold", 0, 1, 0, 1, 0);
    repeat (4) cyc("hold_r2", 0, 1, 0, 0, 0);
    // same-direction reload and opposite tap during a lane-change
    cyc("rel", 0, 0, 0, 0, 0);
    cyc("tap_r", 0, 0, 0, 0, 1);
    repeat (9) cyc("lane_r", 0, 0, 0, 0, 0);
    cyc("reload_r", 0, 0, 0, 0, 1);
    repeat (5) cyc("lane_r2", 0, 0, 0, 0, 0);
    cyc("opp_tap", 0, 0, 0, 1, 0);
    repeat (8) cyc("gap_lane", 0, 0, 0, 0, 0);
    cyc("both_taps", 0, 0, 0, 1, 1);
    // asynchronous reset in the middle of a right lane-change
    cyc("tap_r3", 0, 0, 0, 0, 1);
    repeat (6) cyc("lane_r3", 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    check_all("in_reset");
    reset = 1'b0;
    model_reset();
    repeat (9) cyc("post_reset", 0, 0, 0, 0, 0);

    // random traffic
    rl = 0; rr = 0; hz = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        sel = $urandom_range(0, 3);
        rl = sel[0]; rr = sel[1];
      end
      if (hz) begin
        if ($urandom_range(0, 14) == 0) hz = 0;
      end else if ($urandom_range(0, 59) == 0) hz = 1;
      tl = ($urandom_range(0, 9) == 0);
      tr = ($urandom_range(0, 9) == 0);
      cyc("rand", rl, rr, hz, tl, tr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
